// File: rtl/axis_mover.sv
// One-axis position engine: registered position advanced by STEP on tick.
// MODE 0 is a saturating paddle; MODE 1 is a bouncing ball with edge events.
module axis_mover #(
  parameter int WIDTH = 10,
  parameter int MIN   = 0,
  parameter int MAX   = 639,
  parameter int STEP  = 1,
  parameter int INIT  = 320,
  parameter int MODE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             up,
  input  logic             down,
  input  logic             start,
  input  logic             stop,
  input  logic             dir_init,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] pos,
  output logic             dir,
  output logic             moving,
  output logic             at_min,
  output logic             at_max,
  output logic             bounce,
  output logic [1:0]       edge_hit
);

  localparam int WX = WIDTH + 1;

  // Bound comparisons use one spare bit so pos+STEP can never wrap.
  localparam logic [WIDTH:0]   MIN_X  = WX'(MIN);
  localparam logic [WIDTH:0]   MAX_X  = WX'(MAX);
  localparam logic [WIDTH:0]   STEP_X = WX'(STEP);
  localparam logic [WIDTH-1:0] MIN_W  = WIDTH'(MIN);
  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic             bounce_q, bounce_d;
  logic [1:0]       edge_q, edge_d;

  logic [WIDTH:0]   pos_x;
  logic [WIDTH:0]   inc_x;
  logic             hit_max;
  logic             hit_min;
  logic [WIDTH-1:0] inc_w;
  logic [WIDTH-1:0] dec_w;
  logic [WIDTH-1:0] load_clamped;

  // inc_w/dec_w are only selected when the wide compare proves they stay in range.
  assign pos_x   = {1'b0, pos_q};
  assign inc_x   = pos_x + STEP_X;
  assign hit_max = (inc_x >= MAX_X);
  assign hit_min = (pos_x <= MIN_X + STEP_X);
  assign inc_w   = pos_q + STEP_W;
  assign dec_w   = pos_q - STEP_W;

  assign load_clamped = (load_val < MIN_W) ? MIN_W :
                        (load_val > MAX_W) ? MAX_W : load_val;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d  = state_q;
    pos_d    = pos_q;
    dir_d    = dir_q;
    bounce_d = 1'b0;
    edge_d   = 2'b00;

    if (load) begin
      pos_d = load_clamped;
    end else if (MODE == 0) begin
      if (tick && up && !down) begin
        dir_d = 1'b1;
        pos_d = hit_max ? MAX_W : inc_w;
      end else if (tick && down && !up) begin
        dir_d = 1'b0;
        pos_d = hit_min ? MIN_W : dec_w;
      end
    end else begin
      if (state_q == RUN && stop) begin
        state_d = IDLE;
      end else if (state_q == IDLE && start && !stop) begin
        state_d = RUN;
        dir_d   = dir_init;
      end else if (state_q == RUN && tick) begin
        if (dir_q) begin
          if (hit_max) begin
            pos_d    = MAX_W;
            dir_d    = 1'b0;
            bounce_d = 1'b1;
            edge_d   = 2'b10;
          end else begin
            pos_d = inc_w;
          end
        end else begin
          if (hit_min) begin
            pos_d    = MIN_W;
            dir_d    = 1'b1;
            bounce_d = 1'b1;
            edge_d   = 2'b01;
          end else begin
            pos_d = dec_w;
          end
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pos_q    <= INIT_W;
      dir_q    <= 1'b1;
      bounce_q <= 1'b0;
      edge_q   <= 2'b00;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      bounce_q <= bounce_d;
      edge_q   <= edge_d;
    end
  end

  assign pos      = pos_q;
  assign dir      = dir_q;
  assign moving   = (MODE == 1) && (state_q == RUN);
  assign at_min   = (pos_q == MIN_W);
  assign at_max   = (pos_q == MAX_W);
  assign bounce   = bounce_q;
  assign edge_hit = edge_q;

endmodule

// File: tb/tb_axis_mover.sv
// Bench for axis_mover: five parameterisations share one stimulus stream and are
// compared every cycle against an integer reference model, plus directed scenarios.
module tb_axis_mover;

  localparam int N = 5;
  localparam int P_MIN  [N] = '{0,   0,   16,  0,   10};
  localparam int P_MAX  [N] = '{639, 639, 639, 639, 20};
  localparam int P_STEP [N] = '{1,   8,   1,   4,   10};
  localparam int P_INIT [N] = '{320, 320, 320, 320, 15};
  localparam int P_MODE [N] = '{0,   0,   0,   1,   1};

  logic       clk = 1'b0;
  logic       rst, tick, up, down, start, stop, dir_init, load;
  logic [9:0] load_val;

  logic [9:0] pos_o    [N];
  logic       dir_o    [N];
  logic       moving_o [N];
  logic       at_min_o [N];
  logic       at_max_o [N];
  logic       bounce_o [N];
  logic [1:0] edge_o   [N];

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int pos;
    bit dir;
    bit run;
    bit bounce;
    int edge_hit;
  } mdl_t;

  mdl_t m [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    axis_mover #(
      .WIDTH(10), .MIN(P_MIN[g]), .MAX(P_MAX[g]), .STEP(P_STEP[g]),
      .INIT(P_INIT[g]), .MODE(P_MODE[g])
    ) u_dut (
      .clk(clk), .rst(rst), .tick(tick), .up(up), .down(down),
      .start(start), .stop(stop), .dir_init(dir_init), .load(load),
      .load_val(load_val), .pos(pos_o[g]), .dir(dir_o[g]),
      .moving(moving_o[g]), .at_min(at_min_o[g]), .at_max(at_max_o[g]),
      .bounce(bounce_o[g]), .edge_hit(edge_o[g])
    );
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Next model state from the rules, using the input values present at the edge.
  function automatic mdl_t mstep(mdl_t s, int i);
    mdl_t n;
    int   mn, mx, st, lv;
    n  = s;
    mn = P_MIN[i];
    mx = P_MAX[i];
    st = P_STEP[i];
    lv = int'(load_val);
    n.bounce   = 1'b0;
    n.edge_hit = 0;
    if (rst) begin
      n.pos = P_INIT[i];
      n.dir = 1'b1;
      n.run = 1'b0;
    end else if (load) begin
      n.pos = (lv < mn) ? mn : (lv > mx) ? mx : lv;
    end else if (P_MODE[i] == 0) begin
      if (tick && up && !down) begin
        n.dir = 1'b1;
        n.pos = (s.pos + st > mx) ? mx : s.pos + st;
      end else if (tick && down && !up) begin
        n.dir = 1'b0;
        n.pos = (s.pos - st < mn) ? mn : s.pos - st;
      end
    end else if (stop) begin
      n.run = 1'b0;
    end else if (start && !s.run) begin
      n.run = 1'b1;
      n.dir = dir_init;
    end else if (s.run && tick) begin
      if (s.dir) begin
        if (s.pos + st >= mx) begin
          n.pos = mx; n.dir = 1'b0; n.bounce = 1'b1; n.edge_hit = 2;
        end else begin
          n.pos = s.pos + st;
        end
      end else begin
        if (s.pos - st <= mn) begin
          n.pos = mn; n.dir = 1'b1; n.bounce = 1'b1; n.edge_hit = 1;
        end else begin
          n.pos = s.pos - st;
        end
      end
    end
    return n;
  endfunction

  // One clock: advance the models at the edge, then compare every instance 1 ns later.
  task automatic cyc();
    @(posedge clk);
    for (int i = 0; i < N; i++) m[i] = mstep(m[i], i);
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("u%0d.pos", i),      int'(pos_o[i]),    m[i].pos);
      check($sformatf("u%0d.dir", i),      int'(dir_o[i]),    int'(m[i].dir));
      check($sformatf("u%0d.moving", i),   int'(moving_o[i]), int'(P_MODE[i] == 1 && m[i].run));
      check($sformatf("u%0d.at_min", i),   int'(at_min_o[i]), int'(m[i].pos == P_MIN[i]));
      check($sformatf("u%0d.at_max", i),   int'(at_max_o[i]), int'(m[i].pos == P_MAX[i]));
      check($sformatf("u%0d.bounce", i),   int'(bounce_o[i]), int'(m[i].bounce));
      check($sformatf("u%0d.edge_hit", i), int'(edge_o[i]),   m[i].edge_hit);
    end
  endtask

  task automatic idle_inputs();
    tick = 0; up = 0; down = 0; start = 0; stop = 0;
    dir_init = 0; load = 0; load_val = '0;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    cyc();
    cyc();
    check("reset_pos", int'(pos_o[0]), 320);
    check("reset_dir", int'(dir_o[0]), 1);
    check("reset_moving", int'(moving_o[3]), 0);
    check("reset_bounce", int'(bounce_o[3]), 0);

    // Paddle, STEP 1: five up ticks.
    rst = 0; up = 1; tick = 1;
    repeat (5) cyc();
    check("paddle_up5", int'(pos_o[0]), 325);
    check("paddle_up5_at_min", int'(at_min_o[0]), 0);
    check("paddle_up5_at_max", int'(at_max_o[0]), 0);
    check("paddle_no_bounce", int'(bounce_o[0]), 0);

    // Paddle, STEP 8: saturation at MAX, then down, then up&down hold.
    load = 1; load_val = 10'd636;
    cyc();
    check("load_ignores_tick", int'(pos_o[1]), 636);
    load = 0;
    cyc();
    check("sat_max", int'(pos_o[1]), 639);
    check("sat_max_flag", int'(at_max_o[1]), 1);
    cyc();
    check("sat_max_hold", int'(pos_o[1]), 639);
    up = 0; down = 1;
    cyc();
    check("step_down", int'(pos_o[1]), 631);
    up = 1;
    cyc();
    check("up_down_hold", int'(pos_o[1]), 631);

    // Load clamping at both ends.
    up = 0; down = 0; load = 1; load_val = 10'd1000;
    cyc();
    check("load_clamp_hi", int'(pos_o[0]), 639);
    load_val = 10'd0; up = 1;
    cyc();
    check("load_clamp_lo", int'(pos_o[2]), 16);
    check("load_zero", int'(pos_o[0]), 0);
    idle_inputs();

    // Ball, STEP 4: approach MAX and bounce; u4 bounces on consecutive ticks.
    load = 1; load_val = 10'd630;
    cyc();
    load = 0; start = 1; dir_init = 1;
    cyc();
    check("ball_start_moving", int'(moving_o[3]), 1);
    check("ball_start_no_move", int'(pos_o[3]), 630);
    start = 0; tick = 1;
    cyc();
    check("ball_634", int'(pos_o[3]), 634);
    check("narrow_hit_max", int'(edge_o[4]), 2);
    cyc();
    check("ball_638", int'(pos_o[3]), 638);
    check("narrow_hit_min", int'(edge_o[4]), 1);
    check("narrow_back_to_back", int'(bounce_o[4]), 1);
    cyc();
    check("ball_hit_pos", int'(pos_o[3]), 639);
    check("ball_hit_bounce", int'(bounce_o[3]), 1);
    check("ball_hit_edge", int'(edge_o[3]), 2);
    check("ball_hit_dir", int'(dir_o[3]), 0);
    cyc();
    check("ball_return", int'(pos_o[3]), 635);
    check("ball_bounce_pulse", int'(bounce_o[3]), 0);

    // Load in RUN near MIN, then hit MIN; stop+start together halts.
    tick = 0; load = 1; load_val = 10'd3;
    cyc();
    check("run_load_pos", int'(pos_o[3]), 3);
    check("run_load_moving", int'(moving_o[3]), 1);
    load = 0; tick = 1;
    cyc();
    check("min_hit_pos", int'(pos_o[3]), 0);
    check("min_hit_edge", int'(edge_o[3]), 1);
    check("min_hit_dir", int'(dir_o[3]), 1);
    stop = 1; start = 1;
    cyc();
    check("stop_wins", int'(moving_o[3]), 0);
    cyc();
    check("stop_start_idle", int'(moving_o[3]), 0);
    stop = 0; start = 0;
    repeat (3) cyc();
    check("idle_hold", int'(pos_o[3]), 0);

    // Reset in RUN with tick high, then relaunch from INIT.
    start = 1; dir_init = 0; tick = 0;
    cyc();
    start = 0; tick = 1;
    cyc();
    cyc();
    rst = 1;
    cyc();
    check("rst_run_pos", int'(pos_o[3]), 320);
    check("rst_run_dir", int'(dir_o[3]), 1);
    check("rst_run_moving", int'(moving_o[3]), 0);
    check("rst_run_bounce", int'(bounce_o[3]), 0);
    rst = 0; tick = 0; start = 1; dir_init = 1;
    cyc();
    start = 0; tick = 1;
    cyc();
    check("relaunch", int'(pos_o[3]), 324);

    // Random traffic, every instance checked against the model each cycle.
    for (int k = 0; k < 800; k++) begin
      rst      = ($urandom_range(63) == 0);
      tick     = $urandom_range(1);
      up       = $urandom_range(1);
      down     = $urandom_range(1);
      start    = ($urandom_range(7) == 0);
      stop     = ($urandom_range(11) == 0);
      dir_init = $urandom_range(1);
      load     = ($urandom_range(9) == 0);
      load_val = 10'($urandom);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axis_mover.md
Name: axis_mover

Overview:
- Parametrised one-axis position engine for paddles and the ball. It replaces the fixed 10-bit combinational rest/up/down adders with a registered position.
- Position advances by a configurable STEP on a qualified tick. Bounds handling is built in.
- MODE 0 (paddle): player up/down requests, saturating at the limits.
- MODE 1 (ball): autonomous motion with a direction state machine that bounces at the limits and emits edge events for the score logic.

Parameters:
- WIDTH, 10: position width in bits.
- MIN, 0: lowest legal position.
- MAX, 639: highest legal position.
- STEP, 1: increment per tick. Requires 1 <= STEP <= MAX-MIN.
- INIT, 320: reset position. Requires MIN <= INIT <= MAX.
- MODE, 0: 0 = paddle (saturating, input-driven); 1 = ball (bounce, autonomous).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous active-high reset.
- tick, input, 1: movement enable. One advance per cycle that tick is high.
- up, input, 1: MODE 0 increment request. Ignored in MODE 1.
- down, input, 1: MODE 0 decrement request. Ignored in MODE 1.
- start, input, 1: MODE 1 launch request. Ignored in MODE 0.
- stop, input, 1: MODE 1 halt request. Ignored in MODE 0.
- dir_init, input, 1: MODE 1 direction latched on start. 1 = increasing.
- load, input, 1: synchronous position load.
- load_val, input, WIDTH: value to load. Clamped to [MIN, MAX].
- pos, output, WIDTH: registered position.
- dir, output, 1: current direction. 1 = increasing.
- moving, output, 1: MODE 1 high in RUN state. Tied 0 in MODE 0.
- at_min, output, 1: pos == MIN. Combinational from pos.
- at_max, output, 1: pos == MAX. Combinational from pos.
- bounce, output, 1: one-cycle pulse on the cycle pos is clamped at a limit while in RUN.
- edge_hit, output, 2: one-cycle pulse marking which limit was hit. [0] = MIN, [1] = MAX.

Behaviour:

Reset and arithmetic:
- Reset: rst high at a clk edge sets pos=INIT, dir=1, state=IDLE, bounce=0, edge_hit=0.
- Reset overrides all other inputs. Reset mid-RUN returns to IDLE at INIT.
- Arithmetic is done at WIDTH+1 bits, so pos+STEP overflow and pos-STEP underflow never wrap.
- Next position is always clamped to [MIN, MAX]. pos never leaves the range.
- Latency: pos, dir, bounce and edge_hit update one clk after the qualifying inputs. They are registered.

Priority (highest first):
- rst, then load, then stop/start, then tick movement.
- load sets pos=clamp(load_val) that cycle. Any tick that cycle is ignored. State and dir are unchanged.

MODE 0 (paddle) on tick:
- up & ~down: pos = min(pos+STEP, MAX).
- down & ~up: pos = max(pos-STEP, MIN).
- up&down, or neither: hold.
- No tick: hold.
- bounce and edge_hit stay 0.
- dir records the last accepted move direction.

MODE 1 (ball) state machine, states IDLE and RUN:
- IDLE: pos holds and tick is ignored. start moves to RUN and latches dir=dir_init. First movement happens on the first tick after entry.
- RUN with dir=1, on tick:
  - If pos+STEP >= MAX: pos=MAX, dir=0, bounce=1, edge_hit[1]=1.
  - Otherwise: pos += STEP.
- RUN with dir=0, on tick:
  - If pos <= MIN+STEP: pos=MIN, dir=1, bounce=1, edge_hit[0]=1.
  - Otherwise: pos -= STEP.
- A landing exactly on a limit counts as a hit.
- RUN on stop: go to IDLE. pos and dir hold.
- stop and start in the same cycle: stop wins.
- start while already in RUN: ignored.

Event and load rules:
- bounce and edge_hit are high for exactly one cycle per hit. They are 0 on all other cycles.
- Back-to-back hits are allowed on consecutive ticks, e.g. when STEP equals MAX-MIN.
- load in RUN keeps RUN and generates no bounce, even if the loaded value sits on a limit.

Test Plan:
- Reset, then MODE 0 defaults, up=1 with tick on 5 cycles: pos 320 to 325; at_min=0, at_max=0; bounce never asserts.
- MODE 0, STEP=8, load 636, then up+tick: pos=639, at_max=1. A further up+tick holds 639. down+tick gives 631. up&down+tick holds.
- MODE 0, load_val=1000 -> pos=639. Then load_val=0 with MIN=16 -> pos=16. A tick in the same cycle as load is ignored.
- MODE 1, STEP=4, load 630, start with dir_init=1, then ticks:
  - pos 634, then 638, then 639 with bounce=1, edge_hit=2'b10 and dir=0 on that cycle.
  - Next tick gives pos 635.
- MODE 1, RUN at pos 3 with dir=0, STEP=4: tick gives pos=0, edge_hit=2'b01, dir=1. Then stop and start asserted together: state stays IDLE, and further ticks leave pos=0.
- MODE 1 in RUN, assert rst with tick high: next cycle pos=320, dir=1, moving=0, bounce=0. start then resumes movement from 320.
